// File: rtl/uart_tx_monitor.sv
// Passive 8N1 UART line monitor: decodes characters seen on a TX line,
// counts them and flags framing errors.
module uart_tx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PRINT_EN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_tx_i,
    output logic [7:0]  char_o,
    output logic        char_valid_o,
    output logic        frame_err_o,
    output logic [31:0] char_count_o
);

    localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [1:0]  r_fill;
    logic        r_armed;
    logic [15:0] r_timer;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit;

    logic        w_fall;
    logic        w_half;
    logic        w_full;
    logic        w_timer_clr;
    logic        w_shift_en;
    logic        w_char_done;
    logic        w_frame_err;

    // Edges are only trusted once the line has really been seen high,
    // so a frame caught mid-flight at reset release is not decoded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= uart_tx_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fall = r_armed & r_prev & ~r_sync2;
    assign w_half = (r_timer == LP_HALF);
    assign w_full = (r_timer == LP_FULL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_timer_clr = 1'b0;
        w_shift_en  = 1'b0;
        w_char_done = 1'b0;
        w_frame_err = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next      = S_START;
                    w_timer_clr = 1'b1;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_timer_clr = 1'b1;
                    w_next      = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full) begin
                    w_timer_clr = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_full) begin
                    w_timer_clr = 1'b1;
                    if (r_sync2) begin
                        w_char_done = 1'b1;
                        w_next      = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_next      = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_sync2) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer <= '0;
            r_shift <= '0;
            r_bit   <= '0;
        end else begin
            if (w_timer_clr || r_state == S_IDLE
                || r_state == S_WAIT_IDLE) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 16'd1;
            end
            if (r_state == S_START) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            char_o       <= '0;
            char_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            char_count_o <= '0;
        end else begin
            char_valid_o <= w_char_done;
            frame_err_o  <= w_frame_err;
            if (w_char_done) begin
                char_o       <= r_shift;
                char_count_o <= char_count_o + 32'd1;
            end
        end
    end

    generate
        if (PRINT_EN) begin : g_print
`ifndef SYNTHESIS
            always_ff @(posedge clk_i) begin
                if (char_valid_o) begin
                    $write("%c", char_o);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Scoreboard bench for uart_tx_monitor: a UART line driver feeds frames
// while a monitor process compares each output pulse with the model queue.
module tb_uart_tx_monitor;

    localparam int CPB = 16;

    typedef struct {
        bit          err;
        logic [7:0]  ch;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line = 1'b1;
    logic [7:0]  char_o;
    logic        char_valid_o;
    logic        frame_err_o;
    logic [31:0] char_count_o;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;
    logic [7:0]  last_ch = 0;

    uart_tx_monitor #(
        .CLKS_PER_BIT (CPB),
        .PRINT_EN     (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .uart_tx_i    (line),
        .char_o       (char_o),
        .char_valid_o (char_valid_o),
        .frame_err_o  (frame_err_o),
        .char_count_o (char_count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Model: a frame with a high stop bit is a new character, otherwise a
    // framing error that leaves the last character and count untouched.
    task automatic expect_frame(input logic [7:0] b, input bit stop_hi);
        exp_t e;
        if (stop_hi) begin
            exp_cnt = exp_cnt + 32'd1;
            last_ch = b;
        end
        e.err = !stop_hi;
        e.ch  = last_ch;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    // pct stretches every bit: 103 = 3% slow, 97 = 3% fast.
    task automatic send_frame(input logic [7:0] b, input int pct,
                              input bit stop_hi);
        logic [9:0] bits;
        int t;
        int lim;
        expect_frame(b, stop_hi);
        bits = {stop_hi, b, 1'b0};
        t = 0;
        for (int i = 0; i < 10; i++) begin
            line = bits[i];
            lim = ((i + 1) * CPB * pct + 50) / 100;
            while (t < lim) begin
                tick();
                t++;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (char_valid_o || frame_err_o)) begin
                chk("exclusive_pulses",
                    32'(char_valid_o & frame_err_o), 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%0b ferr=%0b",
                             char_valid_o, frame_err_o);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", 32'(frame_err_o), 32'(e.err));
                    chk("char_o", 32'(char_o), 32'(e.ch));
                    chk("char_count", char_count_o, e.cnt);
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) begin
            tick();
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_char"}, 32'(char_o), 32'h0);
        chk({tag, "_valid"}, 32'(char_valid_o), 32'h0);
        chk({tag, "_ferr"}, 32'(frame_err_o), 32'h0);
        chk({tag, "_count"}, char_count_o, 32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        int         pct;
        bit         sh;
        logic [7:0] ab;

        fork
            monitor();
        join_none

        repeat (4) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (10) tick();

        send_frame(8'h41, 100, 1'b1);
        repeat (20) tick();
        drain();

        send_frame(8'h48, 100, 1'b1);
        send_frame(8'h69, 100, 1'b1);
        send_frame(8'h0A, 100, 1'b1);
        drain();
        chk("count_after_Hi", char_count_o, 32'd4);

        line = 1'b0;
        repeat (5) tick();
        line = 1'b1;
        repeat (60) tick();
        chk("glitch_count", char_count_o, exp_cnt);

        send_frame(8'h55, 100, 1'b0);
        repeat (40) tick();
        line = 1'b1;
        repeat (20) tick();
        send_frame(8'h31, 100, 1'b1);
        drain();

        send_frame(8'h00, 103, 1'b1);
        send_frame(8'hFF, 103, 1'b1);
        send_frame(8'h00, 97, 1'b1);
        send_frame(8'hFF, 97, 1'b1);
        drain();

        for (int n = 0; n < 30; n++) begin
            rb  = 8'($urandom);
            pct = 97 + 3 * int'($urandom_range(0, 2));
            sh  = ($urandom_range(0, 4) != 0);
            send_frame(rb, pct, sh);
            line = 1'b1;
            if (sh) begin
                repeat ($urandom_range(0, 20)) tick();
            end else begin
                repeat ($urandom_range(20, 40)) tick();
            end
        end
        drain();

        ab = 8'hA5;
        line = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            line = ab[i];
            repeat (CPB) tick();
        end
        line = ab[4];
        repeat (CPB / 2) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk_reset_vals("midframe_rst");
        line = 1'b1;
        rst = 1'b0;
        exp_cnt = 0;
        last_ch = 0;
        repeat (200) tick();
        chk("post_rst_quiet", char_count_o, 32'd0);
        send_frame(8'h7E, 100, 1'b1);
        drain();
        chk("final_count", char_count_o, 32'd1);

        repeat (50) tick();
        chk("no_stray_pulses", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
